order_25d_ctrl: RTL and testbench

ORDER_25D_CTRL -- requirements
Module: order_25d_ctrl

---
 rtl/order_25d_ctrl.sv | 113 +++++++++++
 tb/tb_order_25d_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_25d_ctrl.sv
// Sequencing controller for a free-running 25-input sorter: gathers a 25-sample
// window, holds it steady for the sorter latency, then hands off one ranked value.
module order_25d_ctrl #(
  parameter int DSIZE    = 64,
  parameter int SORT_LAT = 2
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [DSIZE-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          rank_sel,
  output logic [25*DSIZE-1:0] sort_id,
  input  logic [25*DSIZE-1:0] sort_od,
  output logic [DSIZE-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [4:0]          load_cnt
);

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid never depends on ready, and ready never depends on valid.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DSIZE-1:0] win [25];
  logic [3:0]       wait_cnt;
  logic [4:0]       rank;
  logic [DSIZE-1:0] rank_val;
  logic             accept;
  logic             last_accept;
  logic             wait_done;
  logic             handoff;

  assign accept      = in_valid && (state == ST_LOAD);
  assign last_accept = accept && (load_cnt == 5'd24);
  assign wait_done   = (state == ST_WAIT) && (wait_cnt == 4'd0);
  assign handoff     = (state == ST_OUT) && out_ready;

  // The sorter sees the window registers directly; they only move on accepts.
  for (genvar k = 0; k < 25; k++) begin : g_sort_id
    assign sort_id[k*DSIZE +: DSIZE] = win[k];
  end

  always_comb begin
    rank_val = '0;
    for (int k = 0; k < 25; k++) begin
      if (rank == 5'(k)) rank_val = sort_od[k*DSIZE +: DSIZE];
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (last_accept) state_nxt = ST_WAIT;
      ST_WAIT: if (wait_done)   state_nxt = ST_OUT;
      ST_OUT:  if (handoff)     state_nxt = ST_LOAD;
      default:                  state_nxt = ST_LOAD;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = (state == ST_LOAD);
    busy     = (state == ST_WAIT) || (state == ST_OUT);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      load_cnt  <= 5'd0;
      wait_cnt  <= 4'd0;
      rank      <= 5'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < 25; k++) win[k] <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < 25; k++) begin
          if (load_cnt == 5'(k)) win[k] <= in_data;
        end
        load_cnt <= load_cnt + 5'd1;
      end
      // Rank is frozen at the 25th accept; out-of-range ranks pick the maximum.
      if (last_accept) begin
        wait_cnt <= 4'(SORT_LAT);
        rank     <= (rank_sel > 5'd24) ? 5'd24 : rank_sel;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (wait_done) begin
        out_data  <= rank_val;
        out_valid <= 1'b1;
      end else if (handoff) begin
        out_valid <= 1'b0;
        load_cnt  <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_order_25d_ctrl.sv
// Randomized scoreboard bench for order_25d_ctrl: three controllers (sorter
// latency 2, 1, 15) each paired with a behavioural ascending sorter pipeline.
module tb_order_25d_ctrl;

  localparam int DW = 8;
  localparam int NI = 3;
  localparam int WW = 25 * DW;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic [DW-1:0] in_data   [NI];
  logic          in_valid  [NI];
  logic          in_ready  [NI];
  logic [4:0]    rank_sel  [NI];
  logic [WW-1:0] sort_id   [NI];
  logic [WW-1:0] sort_od   [NI];
  logic [DW-1:0] out_data  [NI];
  logic          out_valid [NI];
  logic          out_ready [NI];
  logic          busy      [NI];
  logic [4:0]    load_cnt  [NI];

  int cyc     = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected value, owning instance and first-valid cycle
  logic [DW-1:0] exp_q [$];
  int            exp_inst_q [$];
  int            exp_due_q [$];

  // Reference model state per instance
  logic          m_loading [NI];
  int            m_cnt     [NI];
  logic [DW-1:0] m_win     [NI][25];
  int            m_due     [NI];
  logic          seen      [NI];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  function automatic logic [WW-1:0] sort_win(input logic [WW-1:0] v);
    logic [DW-1:0] a [25];
    logic [DW-1:0] t;
    logic [WW-1:0] r;
    for (int k = 0; k < 25; k++) a[k] = v[k*DW +: DW];
    for (int p = 0; p < 24; p++) begin
      for (int k = 0; k < 24 - p; k++) begin
        if (a[k] > a[k+1]) begin
          t = a[k]; a[k] = a[k+1]; a[k+1] = t;
        end
      end
    end
    r = '0;
    for (int k = 0; k < 25; k++) r[k*DW +: DW] = a[k];
    return r;
  endfunction

  // ---------------- DUTs with behavioural sorters ----------------
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    logic [WW-1:0] pipe [LAT];

    always @(posedge clock) begin
      pipe[0] <= sort_win(sort_id[g]);
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign sort_od[g] = pipe[LAT-1];

    order_25d_ctrl #(.DSIZE(DW), .SORT_LAT(LAT)) u_dut (
      .clock     (clock),
      .rst       (rst),
      .in_data   (in_data[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .rank_sel  (rank_sel[g]),
      .sort_id   (sort_id[g]),
      .sort_od   (sort_od[g]),
      .out_data  (out_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .busy      (busy[g]),
      .load_cnt  (load_cnt[g])
    );
  end

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h expected=%0h", name, inst, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (samples at negedge) ----------------
  initial begin : model_p
    logic [WW-1:0] pk;
    logic [WW-1:0] srt;
    int r;
    for (int i = 0; i < NI; i++) begin
      m_loading[i] = 1'b1; m_cnt[i] = 0; m_due[i] = 0;
      for (int k = 0; k < 25; k++) m_win[i][k] = '0;
    end
    forever begin
      @(negedge clock);
      if (rst) begin
        for (int i = 0; i < NI; i++) begin
          m_loading[i] = 1'b1; m_cnt[i] = 0; m_due[i] = 0;
          for (int k = 0; k < 25; k++) m_win[i][k] = '0;
        end
        exp_q.delete(); exp_inst_q.delete(); exp_due_q.delete();
      end else begin
        for (int i = 0; i < NI; i++) begin
          check("in_ready", i, in_ready[i], m_loading[i]);
          check("busy", i, busy[i], !m_loading[i]);
          check("load_cnt", i, load_cnt[i], m_cnt[i]);
          pk = '0;
          for (int k = 0; k < 25; k++) pk[k*DW +: DW] = m_win[i][k];
          n_checks++;
          if (sort_id[i] !== pk) begin
            n_fail++;
            $display("FAIL sort_id inst=%0d cyc=%0d actual=%h expected=%h", i, cyc, sort_id[i], pk);
          end
          if (!m_loading[i] && cyc >= m_due[i]) check("out_valid_due", i, out_valid[i], 1'b1);

          if (m_loading[i]) begin
            if (in_valid[i] === 1'b1) begin
              m_win[i][m_cnt[i]] = in_data[i];
              m_cnt[i]++;
              if (m_cnt[i] == 25) begin
                m_loading[i] = 1'b0;
                r = (rank_sel[i] > 5'd24) ? 24 : int'(rank_sel[i]);
                pk = '0;
                for (int k = 0; k < 25; k++) pk[k*DW +: DW] = m_win[i][k];
                srt = sort_win(pk);
                m_due[i] = cyc + lat_of(i) + 2;
                exp_q.push_back(srt[r*DW +: DW]);
                exp_inst_q.push_back(i);
                exp_due_q.push_back(m_due[i]);
              end
            end
          end else if (cyc >= m_due[i] && out_ready[i] === 1'b1) begin
            m_loading[i] = 1'b1;
            m_cnt[i] = 0;
          end
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin : monitor_p
    for (int i = 0; i < NI; i++) seen[i] = 1'b0;
    forever begin
      @(negedge clock);
      if (rst) begin
        for (int i = 0; i < NI; i++) seen[i] = 1'b0;
      end else begin
        for (int i = 0; i < NI; i++) begin
          if (out_valid[i] === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0 || exp_inst_q[0] != i) begin
              n_fail++;
              $display("FAIL unexpected_out_valid inst=%0d cyc=%0d actual=1 expected=0", i, cyc);
            end else begin
              if (!seen[i]) begin
                check("out_latency", i, cyc, exp_due_q[0]);
                seen[i] = 1'b1;
              end
              check("out_data", i, out_data[i], exp_q[0]);
              if (out_ready[i] === 1'b1) begin
                void'(exp_q.pop_front());
                void'(exp_inst_q.pop_front());
                void'(exp_due_q.pop_front());
                seen[i] = 1'b0;
              end
            end
          end else if (seen[i]) begin
            n_checks++; n_fail++;
            $display("FAIL out_valid_dropped inst=%0d cyc=%0d actual=0 expected=1", i, cyc);
            seen[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // mode 0: back-to-back descending 24..0, 1: alternating gaps, 2: random gaps, 3: back-to-back random
  task automatic load_window(input int i, input int mode, input logic [4:0] rank);
    int guard;
    guard = 0;
    rank_sel[i] = rank;
    while (m_loading[i] && guard < 500) begin
      case (mode)
        0: begin in_valid[i] = 1'b1; in_data[i] = 8'(24 - m_cnt[i]); end
        1: begin in_valid[i] = (guard % 2 == 0); in_data[i] = 8'($urandom_range(0, 255)); end
        2: begin in_valid[i] = ($urandom_range(0, 3) != 0); in_data[i] = 8'($urandom_range(0, 255)); end
        default: begin in_valid[i] = 1'b1; in_data[i] = 8'($urandom_range(0, 255)); end
      endcase
      guard++;
      step();
    end
    in_valid[i] = 1'b0;
    n_checks++;
    if (guard >= 500) begin
      n_fail++;
      $display("FAIL load_timeout inst=%0d cyc=%0d actual=%0d expected<500", i, cyc, guard);
    end
  endtask

  // bp 0: out_ready held high, 1: 10-cycle stall after out_valid, 2: random
  task automatic finish_window(input int i, input logic [4:0] rank_after, input int bp);
    int guard;
    guard = 0;
    rank_sel[i] = rank_after;
    while (!m_loading[i] && guard < 200) begin
      case (bp)
        0:       out_ready[i] = 1'b1;
        1:       out_ready[i] = (cyc >= m_due[i] + 10);
        default: out_ready[i] = 1'($urandom_range(0, 1));
      endcase
      in_valid[i] = 1'($urandom_range(0, 1));
      in_data[i]  = 8'($urandom_range(0, 255));
      guard++;
      step();
    end
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    n_checks++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL handoff_timeout inst=%0d cyc=%0d actual=%0d expected<200", i, cyc, guard);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim_p
    for (int i = 0; i < NI; i++) begin
      in_data[i] = '0; in_valid[i] = 1'b0; rank_sel[i] = 5'd12; out_ready[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    load_window(0, 0, 5'd12);       // median of 24..0
    finish_window(0, 5'd12, 0);
    step();
    load_window(0, 3, 5'd31);       // rank clamp, rank changed during WAIT
    finish_window(0, 5'd0, 0);
    load_window(0, 3, 5'd7);        // backpressure with ignored input pulses
    finish_window(0, 5'd7, 1);
    load_window(0, 1, 5'd3);        // gapped input
    finish_window(0, 5'd3, 0);

    load_window(0, 3, 5'd12);       // reset while waiting on the sorter
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();
    load_window(0, 0, 5'd12);
    finish_window(0, 5'd12, 0);

    load_window(1, 0, 5'd12);       // latency sweep
    finish_window(1, 5'd12, 0);
    load_window(2, 3, 5'd20);
    finish_window(2, 5'd20, 0);

    for (int n = 0; n < 8; n++) begin
      load_window(0, $urandom_range(1, 3), 5'($urandom_range(0, 31)));
      finish_window(0, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end
    load_window(2, 2, 5'd24);
    finish_window(2, 5'd1, 2);

    repeat (5) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain cyc=%0d actual=%0d expected=0", cyc, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog_p
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
